// File: rtl/ctrl_pipeline.sv
// Pipeline control for a 5-stage in-order core: ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall, EX operand forwarding select and HLT drain/halt sequencing.
module ctrl_pipeline (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic [3:0] id_rd,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_regwrite,
  input  logic       id_memtoreg,
  input  logic       id_memwrite,
  input  logic       id_alusrc,
  input  logic [2:0] id_aluop,
  input  logic       id_flush,
  output logic       stall,
  output logic       ex_valid,
  output logic       ex_regwrite,
  output logic       ex_memtoreg,
  output logic       ex_memwrite,
  output logic       ex_alusrc,
  output logic [2:0] ex_aluop,
  output logic [3:0] ex_rs,
  output logic [3:0] ex_rt,
  output logic [3:0] ex_rd,
  output logic       mem_valid,
  output logic       mem_regwrite,
  output logic       mem_memtoreg,
  output logic       mem_memwrite,
  output logic [3:0] mem_rd,
  output logic       wb_valid,
  output logic       wb_regwrite,
  output logic       wb_memtoreg,
  output logic [3:0] wb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       halted
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t     state_q, state_d;

  logic       ex_valid_q, ex_regwrite_q, ex_memtoreg_q, ex_memwrite_q, ex_alusrc_q, ex_hlt_q;
  logic       ex_valid_d, ex_regwrite_d, ex_memtoreg_d, ex_memwrite_d, ex_alusrc_d, ex_hlt_d;
  logic [2:0] ex_aluop_q, ex_aluop_d;
  logic [3:0] ex_rs_q, ex_rt_q, ex_rd_q, ex_rs_d, ex_rt_d, ex_rd_d;

  logic       mem_valid_q, mem_regwrite_q, mem_memtoreg_q, mem_memwrite_q, mem_hlt_q;
  logic [3:0] mem_rd_q;

  logic       wb_valid_q, wb_regwrite_q, wb_memtoreg_q;
  logic [3:0] wb_rd_q;

  logic       hazard, is_hlt, accept;

  always_comb begin
    hazard = id_valid & ex_valid_q & ex_memtoreg_q & (ex_rd_q != 4'd0) &
             ((id_uses_rs & (id_rs == ex_rd_q)) | (id_uses_rt & (id_rt == ex_rd_q)));
    is_hlt = (id_opcode == 4'b1111);
    accept = (state_q == RUN) & id_valid & ~id_flush & ~hazard;

    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        stall = hazard & ~id_flush;
        if (accept && is_hlt) state_d = DRAIN;
      end
      // The HLT leaving MEM this edge lands in WB, which is when the core counts as halted
      DRAIN: begin
        stall = 1'b1;
        if (mem_valid_q && mem_hlt_q) state_d = HALTED;
      end
      HALTED:  stall = 1'b1;
      default: state_d = RUN;
    endcase

    ex_valid_d    = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_memtoreg_d = 1'b0;
    ex_memwrite_d = 1'b0;
    ex_alusrc_d   = 1'b0;
    ex_hlt_d      = 1'b0;
    ex_aluop_d    = 3'd0;
    ex_rs_d       = 4'd0;
    ex_rt_d       = 4'd0;
    ex_rd_d       = 4'd0;
    if (accept) begin
      ex_valid_d    = 1'b1;
      ex_regwrite_d = id_regwrite & ~is_hlt;
      ex_memtoreg_d = id_memtoreg & ~is_hlt;
      ex_memwrite_d = id_memwrite & ~is_hlt;
      ex_alusrc_d   = id_alusrc;
      ex_hlt_d      = is_hlt;
      ex_aluop_d    = id_aluop;
      ex_rs_d       = id_rs;
      ex_rt_d       = id_rt;
      ex_rd_d       = id_rd;
    end

    // MEM result is younger than WB, so it wins when both match
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid_q) begin
      if (mem_valid_q && mem_regwrite_q && mem_rd_q != 4'd0 && mem_rd_q == ex_rs_q)
        fwd_a = 2'b10;
      else if (wb_valid_q && wb_regwrite_q && wb_rd_q != 4'd0 && wb_rd_q == ex_rs_q)
        fwd_a = 2'b01;
      if (mem_valid_q && mem_regwrite_q && mem_rd_q != 4'd0 && mem_rd_q == ex_rt_q)
        fwd_b = 2'b10;
      else if (wb_valid_q && wb_regwrite_q && wb_rd_q != 4'd0 && wb_rd_q == ex_rt_q)
        fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      ex_valid_q     <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memtoreg_q  <= 1'b0;
      ex_memwrite_q  <= 1'b0;
      ex_alusrc_q    <= 1'b0;
      ex_hlt_q       <= 1'b0;
      ex_aluop_q     <= 3'd0;
      ex_rs_q        <= 4'd0;
      ex_rt_q        <= 4'd0;
      ex_rd_q        <= 4'd0;
      mem_valid_q    <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_hlt_q      <= 1'b0;
      mem_rd_q       <= 4'd0;
      wb_valid_q     <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_rd_q        <= 4'd0;
    end else begin
      state_q        <= state_d;
      ex_valid_q     <= ex_valid_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memtoreg_q  <= ex_memtoreg_d;
      ex_memwrite_q  <= ex_memwrite_d;
      ex_alusrc_q    <= ex_alusrc_d;
      ex_hlt_q       <= ex_hlt_d;
      ex_aluop_q     <= ex_aluop_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memtoreg_q <= ex_memtoreg_q;
      mem_memwrite_q <= ex_memwrite_q;
      mem_hlt_q      <= ex_hlt_q;
      mem_rd_q       <= ex_rd_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_regwrite  = ex_regwrite_q;
  assign ex_memtoreg  = ex_memtoreg_q;
  assign ex_memwrite  = ex_memwrite_q;
  assign ex_alusrc    = ex_alusrc_q;
  assign ex_aluop     = ex_aluop_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign mem_valid    = mem_valid_q;
  assign mem_regwrite = mem_regwrite_q;
  assign mem_memtoreg = mem_memtoreg_q;
  assign mem_memwrite = mem_memwrite_q;
  assign mem_rd       = mem_rd_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_memtoreg  = wb_memtoreg_q;
  assign wb_rd        = wb_rd_q;
  assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: directed hazard/forward/halt/reset cases, then
// randomized instruction streams checked against an instruction-level reference model.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memtoreg, id_memwrite;
  logic       id_alusrc, id_flush;
  logic [3:0] id_opcode, id_rs, id_rt, id_rd;
  logic [2:0] id_aluop;
  logic       stall, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc;
  logic [2:0] ex_aluop;
  logic [3:0] ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       mem_valid, mem_regwrite, mem_memtoreg, mem_memwrite;
  logic       wb_valid, wb_regwrite, wb_memtoreg, halted;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_flush(id_flush), .stall(stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_memwrite(mem_memwrite), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
  );

  typedef struct packed {
    bit       valid;
    bit [3:0] op, rs, rt, rd;
    bit       urs, urt, rw, m2r, mw, as;
    bit [2:0] aluop;
    bit       flush;
  } id_t;

  typedef struct packed {
    bit       v, rw, m2r, mw, as, hlt;
    bit [2:0] aluop;
    bit [3:0] rs, rt, rd;
  } ins_t;

  typedef struct packed {
    bit       stall, halted;
    bit [1:0] fa, fb;
    ins_t     ex, mem, wb;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: the instructions occupying EX/MEM/WB, plus halt bookkeeping
  ins_t m_ex, m_mem, m_wb;
  bit   m_hlt_acc, m_halted;
  bit   last_stall;
  id_t  cur;

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_hlt_acc = 1'b0; m_halted = 1'b0; last_stall = 1'b0;
  endtask

  function automatic bit [1:0] fwd_src(input bit [3:0] r);
    if (!m_ex.v) return 2'b00;
    if (m_mem.v && m_mem.rw && m_mem.rd != 4'd0 && m_mem.rd == r) return 2'b10;
    if (m_wb.v && m_wb.rw && m_wb.rd != 4'd0 && m_wb.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic id_t mk(input bit [3:0] op, input bit [3:0] rs, input bit [3:0] rt,
                             input bit [3:0] rd, input bit urs, input bit urt,
                             input bit rw, input bit m2r, input bit fl);
    id_t d;
    d = '0;
    d.valid = 1'b1; d.op = op; d.rs = rs; d.rt = rt; d.rd = rd;
    d.urs = urs; d.urt = urt; d.rw = rw; d.m2r = m2r; d.flush = fl;
    d.aluop = op[2:0];
    return d;
  endfunction

  function automatic id_t rand_id();
    id_t d;
    d.valid = ($urandom_range(0, 9) != 0);
    d.op    = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    d.rs    = 4'($urandom_range(0, 3));
    d.rt    = 4'($urandom_range(0, 3));
    d.rd    = 4'($urandom_range(0, 3));
    d.urs   = 1'($urandom_range(0, 1));
    d.urt   = 1'($urandom_range(0, 1));
    d.rw    = 1'($urandom_range(0, 1));
    d.m2r   = d.rw & ($urandom_range(0, 1) == 0);
    d.mw    = ~d.rw & 1'($urandom_range(0, 1));
    d.as    = 1'($urandom_range(0, 1));
    d.aluop = 3'($urandom_range(0, 7));
    d.flush = ($urandom_range(0, 7) == 0);
    return d;
  endfunction

  task automatic apply(input id_t d);
    id_valid = d.valid; id_opcode = d.op; id_rs = d.rs; id_rt = d.rt; id_rd = d.rd;
    id_uses_rs = d.urs; id_uses_rt = d.urt; id_regwrite = d.rw; id_memtoreg = d.m2r;
    id_memwrite = d.mw; id_alusrc = d.as; id_aluop = d.aluop; id_flush = d.flush;
  endtask

  // One clock cycle: present ID, push the expected outputs for this cycle, advance the model
  task automatic cycle(input id_t d, input bit do_rst);
    exp_t e;
    ins_t nx;
    bit   hazard, accept;
    @(posedge clk);
    #1;
    if (do_rst) begin
      rst_n = 1'b0;
      #2;
      model_reset();
      rst_n = 1'b1;
    end
    apply(d);
    hazard = d.valid && m_ex.v && m_ex.m2r && m_ex.rd != 4'd0 &&
             ((d.urs && d.rs == m_ex.rd) || (d.urt && d.rt == m_ex.rd));
    e.stall  = m_hlt_acc ? 1'b1 : (hazard && !d.flush);
    e.halted = m_halted;
    e.fa     = fwd_src(m_ex.rs);
    e.fb     = fwd_src(m_ex.rt);
    e.ex = m_ex; e.mem = m_mem; e.wb = m_wb;
    sb.push_back(e);

    accept = !m_hlt_acc && d.valid && !d.flush && !hazard;
    nx = '0;
    if (accept) begin
      nx.v = 1'b1; nx.hlt = (d.op == 4'hF);
      nx.rw = d.rw && !nx.hlt; nx.m2r = d.m2r && !nx.hlt; nx.mw = d.mw && !nx.hlt;
      nx.as = d.as; nx.aluop = d.aluop; nx.rs = d.rs; nx.rt = d.rt; nx.rd = d.rd;
      if (nx.hlt) m_hlt_acc = 1'b1;
    end
    m_wb = m_mem; m_mem = m_ex; m_ex = nx;
    if (m_wb.v && m_wb.hlt) m_halted = 1'b1;
    last_stall = e.stall;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: the pipeline presents a full output set every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", stall, e.stall);
        chk("halted", halted, e.halted);
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
        chk("ex_valid", ex_valid, e.ex.v);
        chk("ex_regwrite", ex_regwrite, e.ex.rw);
        chk("ex_memtoreg", ex_memtoreg, e.ex.m2r);
        chk("ex_memwrite", ex_memwrite, e.ex.mw);
        if (e.ex.v) begin
          chk("ex_alusrc", ex_alusrc, e.ex.as);
          chk("ex_aluop", ex_aluop, e.ex.aluop);
          chk("ex_rs", ex_rs, e.ex.rs);
          chk("ex_rt", ex_rt, e.ex.rt);
          chk("ex_rd", ex_rd, e.ex.rd);
        end
        chk("mem_valid", mem_valid, e.mem.v);
        chk("mem_regwrite", mem_regwrite, e.mem.rw);
        chk("mem_memtoreg", mem_memtoreg, e.mem.m2r);
        chk("mem_memwrite", mem_memwrite, e.mem.mw);
        if (e.mem.v) chk("mem_rd", mem_rd, e.mem.rd);
        chk("wb_valid", wb_valid, e.wb.v);
        chk("wb_regwrite", wb_regwrite, e.wb.rw);
        chk("wb_memtoreg", wb_memtoreg, e.wb.m2r);
        if (e.wb.v) chk("wb_rd", wb_rd, e.wb.rd);
        $display("[TB] cyc t=%0t stall=%0b halted=%0b fwd=%0d/%0d ex_v=%0b mem_v=%0b wb_v=%0b",
                 $time, stall, halted, fwd_a, fwd_b, ex_valid, mem_valid, wb_valid);
      end
    end
  end

  initial begin
    id_t idle, lw3, add3, hlt;
    idle = '0;
    lw3  = mk(4'd4, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    add3 = mk(4'd0, 4'd3, 4'd5, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    hlt  = mk(4'hF, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    apply(idle);
    model_reset();
    cycle(idle, 1'b1);

    // Load-use stall, then re-presented ADD forwarded from WB
    cycle(lw3, 1'b0);
    cycle(add3, 1'b0);
    cycle(add3, 1'b0);
    repeat (3) cycle(idle, 1'b0);

    // MEM beats WB when both write r2
    cycle(mk(4'd1, 4'd6, 4'd7, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    cycle(mk(4'd0, 4'd8, 4'd9, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    cycle(mk(4'd0, 4'd2, 4'd2, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    repeat (3) cycle(idle, 1'b0);

    // r0 load never stalls or forwards
    cycle(mk(4'd4, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0);
    cycle(mk(4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    repeat (3) cycle(idle, 1'b0);

    // Hazard together with flush: no stall, bubble
    cycle(lw3, 1'b0);
    add3.flush = 1'b1;
    cycle(add3, 1'b0);
    add3.flush = 1'b0;
    repeat (3) cycle(idle, 1'b0);

    // HLT to full halt, then reset out of HALTED with an ADD waiting
    cycle(hlt, 1'b0);
    repeat (6) cycle(rand_id(), 1'b0);
    cycle(add3, 1'b1);
    repeat (3) cycle(idle, 1'b0);

    // Reset pulse while draining
    cycle(hlt, 1'b0);
    cycle(add3, 1'b0);
    cycle(add3, 1'b1);
    repeat (3) cycle(idle, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      bit rst;
      if (!(last_stall && !m_hlt_acc)) cur = rand_id();
      rst = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
      cycle(cur, rst);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
